// File: rtl/apb_timer_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apb_timer_arb_pkg
// Brief   : Shared types and default sizes for the two-port APB timer arbiter
// Revision: 1.0 - initial release
// ============================================================================
package apb_timer_arb_pkg;

  localparam int C_ADDR_W         = 10;
  localparam int C_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_timer_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin grant; last-grant register advances on accept
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie
  logic r_last;

  // One-hot grant: a lone requester always wins, a tie goes to the other one
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who was granted whenever the grant is actually taken
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_last <= 1'b1;
    end else if (update && (req != 2'b00)) begin
      r_last <= gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_timer_arb.sv
`default_nettype none
// ============================================================================
// Module  : apb_timer_arb
// Brief   : Arbitrates two requesters onto one APB master port with timeout
// Revision: 1.0 - initial release
// ============================================================================
module apb_timer_arb
  import apb_timer_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES,
  parameter int ADDR_W         = C_ADDR_W
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              rsp1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_gid;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [7:0]        r_cnt;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_tmo;

  // A grant is only taken while idle and out of reset
  assign w_accept = presetn && (r_state == ST_IDLE) && (req0_valid || req1_valid);
  assign w_tmo    = (r_cnt == c_tmo_last);

  rr_arb2 u_arb (
    .pclk    (pclk),
    .presetn (presetn),
    .req     ({req1_valid, req0_valid}),
    .update  (w_accept),
    .gnt     (w_gnt)
  );

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and APB phase strobes; pready beats the timeout on a tie
  always_comb begin
    w_next  = r_state;
    psel    = 1'b0;
    penable = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        psel   = 1'b1;
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || w_tmo) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the granted request, count wait states and latch the response
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_gid   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write <= w_gnt[1] ? req1_write : req0_write;
            r_addr  <= w_gnt[1] ? req1_addr  : req0_addr;
            r_wdata <= w_gnt[1] ? req1_wdata : req0_wdata;
            r_gid   <= w_gnt[1];
            r_cnt   <= '0;
          end
        end
        ST_ACCESS: begin
          if (pready) begin
            r_rdata <= (r_write || pslverr) ? 32'd0 : prdata;
            r_err   <= pslverr;
          end else if (w_tmo) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_accept && w_gnt[0];
  assign req1_ready = w_accept && w_gnt[1];

  assign rsp0_valid = (r_state == ST_RESP) && !r_gid;
  assign rsp1_valid = (r_state == ST_RESP) &&  r_gid;
  assign rsp0_rdata = rsp0_valid ? r_rdata : 32'd0;
  assign rsp1_rdata = rsp1_valid ? r_rdata : 32'd0;
  assign rsp0_err   = rsp0_valid && r_err;
  assign rsp1_err   = rsp1_valid && r_err;

  // Address/control/data come straight from the capture registers so they
  // stay put between transfers
  assign paddr  = r_addr;
  assign pwrite = r_write;
  assign pwdata = r_wdata;

endmodule
`default_nettype wire
